// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_pkg
//  Description : Shared types and constants for the Keccak absorb front end:
//                padder state encoding, domain-suffix bytes, rate sizes.
//  Revision    : 1.0  initial release
// ============================================================================
package keccak_pkg;

    typedef enum logic [1:0] {
        ABSORB = 2'd0,
        PAD    = 2'd1,
        WAIT   = 2'd2
    } padder_state_t;

    localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;
    localparam logic [7:0] SUFFIX_SHA3  = 8'h06;

    localparam int RATE_LANES_SHAKE128 = 21;
    localparam int RATE_LANES_SHAKE256 = 17;

endpackage
`default_nettype wire

// File: rtl/keccak_pad_word.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_pad_word
//  Description : Combinational lane formatter. Keeps the first i_nbytes bytes
//                of i_data, zeroes the rest, optionally drops the suffix byte
//                at index i_nbytes and ORs 0x80 into the top byte.
//  Revision    : 1.0  initial release
// ============================================================================
module keccak_pad_word #(
    parameter int         WIDTH  = 64,
    parameter logic [7:0] SUFFIX = 8'h1F
) (
    input  logic [WIDTH-1:0]            i_data,
    input  logic [$clog2(WIDTH/8):0]    i_nbytes,
    input  logic                        i_suffix_en,
    input  logic                        i_final_en,
    output logic [WIDTH-1:0]            o_lane
);

    localparam int c_NB = WIDTH / 8;
    localparam int c_BW = $clog2(c_NB) + 1;

    for (genvar i = 0; i < c_NB; i++) begin : g_byte
        localparam logic [c_BW-1:0] c_IDX = c_BW'(i);
        logic [7:0] w_keep;
        logic [7:0] w_sfx;
        logic [7:0] w_fin;

        // byte i: message byte if below the valid count, suffix exactly at the count
        always_comb begin
            w_keep = (c_IDX < i_nbytes) ? i_data[8*i +: 8] : 8'h00;
            w_sfx  = (i_suffix_en && (c_IDX == i_nbytes)) ? SUFFIX : 8'h00;
            w_fin  = (i_final_en && (i == c_NB - 1)) ? 8'h80 : 8'h00;
        end

        assign o_lane[8*i +: 8] = w_keep | w_sfx | w_fin;
    end

endmodule
`default_nettype wire

// File: rtl/keccak_padder.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_padder
//  Description : Stream front end of the Keccak absorb path. Accepts message
//                words, applies pad10*1 with a domain suffix, emits one lane
//                per cycle into the lane buffer and presents each full rate
//                block until the permutation acknowledges it.
//                Optional macro KECCAK_PADDER_STATS_EN enables block_count.
//  Revision    : 1.0  initial release
// ============================================================================
module keccak_padder
    import keccak_pkg::*;
#(
    parameter int         WIDTH      = 64,
    parameter int         RATE_LANES = 17,
    parameter logic [7:0] SUFFIX     = SUFFIX_SHAKE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_last,
    input  logic [$clog2(WIDTH/8):0]    in_bytes,
    output logic                        out_en,
    output logic [WIDTH-1:0]            out_data,
    output logic                        block_valid,
    output logic                        block_last,
    input  logic                        block_ack,
    output logic [31:0]                 block_count
);

    localparam int c_NB = WIDTH / 8;
    localparam int c_BW = $clog2(c_NB) + 1;
    localparam int c_LW = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [c_LW-1:0] c_LAST_LANE = c_LW'(RATE_LANES - 1);
    localparam logic [c_BW-1:0] c_FULL      = c_BW'(c_NB);

    padder_state_t      r_state, w_state_nxt;
    logic [c_LW-1:0]    r_lane_cnt, w_lane_nxt;
    logic               r_out_en;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_block_valid, w_bv_nxt;
    logic               r_block_last, w_bl_nxt;
    logic               r_sfx_pend, w_sfx_pend_nxt;   // suffix byte still owed
    logic               r_pad_pend, w_pad_pend_nxt;   // message ended, 0x80 not yet emitted
    logic               r_final, w_final_nxt;         // current block carries the 0x80

    logic               w_emit;
    logic               w_ack;
    logic               w_at_last;
    logic [WIDTH-1:0]   w_pw_data;
    logic [c_BW-1:0]    w_pw_nbytes;
    logic               w_pw_sfx;
    logic               w_pw_fin;
    logic [WIDTH-1:0]   w_pw_lane;

    assign w_at_last = (r_lane_cnt == c_LAST_LANE);
    assign in_ready  = rst && (r_state == ABSORB);

    keccak_pad_word #(
        .WIDTH  (WIDTH),
        .SUFFIX (SUFFIX)
    ) u_pad_word (
        .i_data      (w_pw_data),
        .i_nbytes    (w_pw_nbytes),
        .i_suffix_en (w_pw_sfx),
        .i_final_en  (w_pw_fin),
        .o_lane      (w_pw_lane)
    );

    // next-state, lane formatting controls and flag updates
    always_comb begin
        w_state_nxt    = r_state;
        w_lane_nxt     = r_lane_cnt;
        w_emit         = 1'b0;
        w_ack          = 1'b0;
        w_pw_data      = in_data;
        w_pw_nbytes    = c_FULL;
        w_pw_sfx       = 1'b0;
        w_pw_fin       = 1'b0;
        w_sfx_pend_nxt = r_sfx_pend;
        w_pad_pend_nxt = r_pad_pend;
        w_final_nxt    = r_final;
        w_bv_nxt       = r_block_valid;
        w_bl_nxt       = r_block_last;

        case (r_state)
            ABSORB: begin
                if (in_valid) begin
                    w_emit = 1'b1;
                    if (in_last && (in_bytes < c_FULL)) begin
                        // partial final word: suffix goes in-line
                        w_pw_nbytes    = in_bytes;
                        w_pw_sfx       = 1'b1;
                        w_pw_fin       = w_at_last;
                        w_sfx_pend_nxt = 1'b0;
                        if (w_at_last) begin
                            w_final_nxt    = 1'b1;
                            w_pad_pend_nxt = 1'b0;
                            w_state_nxt    = WAIT;
                        end else begin
                            w_pad_pend_nxt = 1'b1;
                            w_state_nxt    = PAD;
                        end
                    end else if (in_last) begin
                        // full final word: suffix deferred to the next lane
                        w_sfx_pend_nxt = 1'b1;
                        w_pad_pend_nxt = 1'b1;
                        w_state_nxt    = w_at_last ? WAIT : PAD;
                    end else begin
                        w_state_nxt    = w_at_last ? WAIT : ABSORB;
                    end
                end
            end
            PAD: begin
                w_emit         = 1'b1;
                w_pw_data      = '0;
                w_pw_nbytes    = '0;
                w_pw_sfx       = r_sfx_pend;
                w_pw_fin       = w_at_last;
                w_sfx_pend_nxt = 1'b0;
                if (w_at_last) begin
                    w_final_nxt    = 1'b1;
                    w_pad_pend_nxt = 1'b0;
                    w_state_nxt    = WAIT;
                end
            end
            WAIT: begin
                // block is presented one cycle after its last lane strobe;
                // an ack only counts once the block is visible
                if (!r_block_valid) begin
                    w_bv_nxt = 1'b1;
                    w_bl_nxt = r_final;
                end else if (block_ack) begin
                    w_ack       = 1'b1;
                    w_bv_nxt    = 1'b0;
                    w_bl_nxt    = 1'b0;
                    w_final_nxt = 1'b0;
                    w_state_nxt = (r_final || !r_pad_pend) ? ABSORB : PAD;
                end
            end
            default: begin
                w_state_nxt = ABSORB;
            end
        endcase

        if (w_emit) begin
            w_lane_nxt = w_at_last ? '0 : r_lane_cnt + c_LW'(1);
        end
    end

    // state, lane counter, lane output register and block flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ABSORB;
            r_lane_cnt    <= '0;
            r_out_en      <= 1'b0;
            r_out_data    <= '0;
            r_block_valid <= 1'b0;
            r_block_last  <= 1'b0;
            r_sfx_pend    <= 1'b0;
            r_pad_pend    <= 1'b0;
            r_final       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lane_cnt    <= w_lane_nxt;
            r_out_en      <= w_emit;
            if (w_emit) begin
                r_out_data <= w_pw_lane;
            end
            r_block_valid <= w_bv_nxt;
            r_block_last  <= w_bl_nxt;
            r_sfx_pend    <= w_sfx_pend_nxt;
            r_pad_pend    <= w_pad_pend_nxt;
            r_final       <= w_final_nxt;
        end
    end

    assign out_en      = r_out_en;
    assign out_data    = r_out_data;
    assign block_valid = r_block_valid;
    assign block_last  = r_block_last;

`ifdef KECCAK_PADDER_STATS_EN
    logic [31:0] r_block_count;

    // count acknowledged blocks, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_block_count <= '0;
        end else if (w_ack) begin
            r_block_count <= r_block_count + 32'd1;
        end
    end

    assign block_count = r_block_count;
`else
    assign block_count = '0;
`endif

endmodule
`default_nettype wire
